// File: rtl/msk_tx_scheduler_if.sv
// Byte-source handshake and modulator drive bundle for msk_tx_scheduler.
// master = byte sources / modulator side, slave = the scheduler itself.
interface msk_tx_scheduler_if;
  logic       req_a;
  logic [7:0] data_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] data_b;
  logic       ack_b;
  logic [7:0] mod_data;
  logic       mod_enable;
  logic       mod_rst_n;
  logic       busy;
  logic       grant_id;
  logic       byte_done;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, mod_data, mod_enable, mod_rst_n, busy, grant_id, byte_done
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, mod_data, mod_enable, mod_rst_n, busy, grant_id, byte_done
  );
endinterface

// File: rtl/msk_tx_scheduler.sv
// MSK TX scheduler: round-robin arbitration of two byte sources, one byte per SEND period.
// Optional MSK_SCHED_PREAMBLE_EN: an 0xAA preamble byte precedes every burst started from IDLE.
//
// state  | meaning
// IDLE   | no byte in flight, modulator held in reset
// LOAD   | arbitrate, latch byte, pulse ack (or load preamble)
// SEND   | modulator enabled for SAMPLES_PER_BIT*BITS_PER_BYTE cycles
// GAP    | modulator reset pulse between bytes
module msk_tx_scheduler #(
  parameter int SAMPLES_PER_BIT = 32,
  parameter int BITS_PER_BYTE   = 8,
  parameter int GAP_CYCLES      = 2
) (
  input  logic              i_g_clk_tx,
  input  logic              i_reset,
  msk_tx_scheduler_if.slave bus
);

  localparam int SEND_LEN = SAMPLES_PER_BIT * BITS_PER_BYTE;
  localparam int CNT_W    = $clog2(SEND_LEN) + 1;
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(SEND_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       PREAMBLE  = 8'hAA;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_mod_data;
  logic             r_grant;
  logic             r_rr;
  logic             w_any_req;
  logic             w_pick_b;
  logic             w_serve;
  logic             w_pre_now;
  logic             w_cnt_zero;

`ifdef MSK_SCHED_PREAMBLE_EN
  logic r_pre;
  assign w_pre_now = (r_state == S_LOAD) && r_pre;
`else
  assign w_pre_now = 1'b0;
`endif

  assign w_any_req  = bus.req_a | bus.req_b;
  // B wins when it is alone or when the round-robin pointer favours it
  assign w_pick_b   = bus.req_b & (~bus.req_a | r_rr);
  assign w_serve    = (r_state == S_LOAD) && w_any_req && !w_pre_now;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_next = S_LOAD;
      S_LOAD: w_next = (w_pre_now || w_any_req) ? S_SEND : S_IDLE;
      S_SEND: if (w_cnt_zero) w_next = S_GAP;
      S_GAP:  if (w_cnt_zero) w_next = w_any_req ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_g_clk_tx) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mod_data <= 8'h00;
      r_grant    <= 1'b0;
      r_rr       <= 1'b0;
`ifdef MSK_SCHED_PREAMBLE_EN
      r_pre      <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
`ifdef MSK_SCHED_PREAMBLE_EN
          if (w_any_req) r_pre <= 1'b1;
`endif
        end
        S_LOAD: begin
          r_cnt <= SEND_LAST;
          if (w_pre_now) begin
            r_mod_data <= PREAMBLE;
            r_grant    <= 1'b0;
`ifdef MSK_SCHED_PREAMBLE_EN
            r_pre      <= 1'b0;
`endif
          end else if (w_serve) begin
            r_mod_data <= w_pick_b ? bus.data_b : bus.data_a;
            r_grant    <= w_pick_b;
            r_rr       <= ~w_pick_b;
          end
        end
        S_SEND: r_cnt <= w_cnt_zero ? GAP_LAST : r_cnt - 1'b1;
        S_GAP:  if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.ack_a      = w_serve && !w_pick_b;
  assign bus.ack_b      = w_serve && w_pick_b;
  assign bus.mod_data   = r_mod_data;
  assign bus.mod_enable = (r_state == S_SEND);
  assign bus.mod_rst_n  = (r_state == S_LOAD) || (r_state == S_SEND);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.grant_id   = r_grant;
  assign bus.byte_done  = (r_state == S_SEND) && w_cnt_zero;

endmodule
